// File: rtl/mulnu_seq_if.sv
// Operand/result handshake bundle for the sequential truncated multiplier.
// The master presents operands and consumes products; the slave is the multiplier.
interface mulnu_seq_if #(
  parameter int W  = 8,
  parameter int TW = $clog2(2*W)
) ();
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [TW-1:0]   trunc;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  o;
  logic            busy;

  modport master (
    output in_valid, a, b, trunc, out_ready,
    input  in_ready, out_valid, o, busy
  );

  modport slave (
    input  in_valid, a, b, trunc, out_ready,
    output in_ready, out_valid, o, busy
  );
endinterface

// File: rtl/mulnu_seq.sv
// Shift-and-add unsigned multiplier, one partial-product row per cycle, with
// optional truncation of the low product columns. Fixed W-cycle CALC phase.
module mulnu_seq #(
  parameter int W  = 8,
  parameter int TW = $clog2(2*W)
) (
  input  logic        clk,
  input  logic        rst,
  mulnu_seq_if.slave  bus
);

  localparam int            JW   = $clog2(W);
  localparam logic [JW-1:0] LAST = JW'(W-1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [W-1:0]    a_q, b_q;
  logic [TW-1:0]   trunc_q;
  logic [2*W-1:0]  acc;
  logic [JW-1:0]   j;
  logic [W-1:0]    row;
  logic [2*W-1:0]  pp;
  logic            accept;
  logic            last_step;

  assign accept    = (state == IDLE) && bus.in_valid;
  assign last_step = (j == LAST);

  // Row j keeps bit i only when its column i+j survives truncation.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    row = '0;
    for (int i = 0; i < W; i++) begin
      row[i] = a_q[i] & b_q[j] & ((i + int'(j)) >= int'(trunc_q));
    end
    pp = {{W{1'b0}}, row} << j;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid)  state_next = CALC;
      CALC:    if (last_step)     state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the operand and accumulator registers are reset too, so o and the
  // mask logic never see X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      trunc_q <= '0;
      acc     <= '0;
      j       <= '0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.b;
      trunc_q <= bus.trunc;
      acc     <= '0;
      j       <= '0;
    end else if (state == CALC) begin
      acc <= acc + pp;
      if (!last_step) j <= j + 1'b1;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.o         = (state == DONE) ? acc : '0;

endmodule

// File: tb/tb_mulnu_seq.sv
// Directed self-checking bench for mulnu_seq at W=8 and W=16, plus a short
// randomised pass checked against a column-sum reference model.
module tb_mulnu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mulnu_seq_if #(.W(8))  if8  ();
  mulnu_seq_if #(.W(16)) if16 ();

  mulnu_seq #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
  mulnu_seq #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Sum of a[i]&b[j]*2^(i+j) over surviving columns i+j >= t.
  function automatic logic [63:0] model(input int w, input logic [31:0] av,
                                        input logic [31:0] bv, input int t);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < w; i++)
      for (int k = 0; k < w; k++)
        if (av[i] && bv[k] && (i + k) >= t) s = s + (64'd1 << (i + k));
    return s;
  endfunction

  // Issue one W=8 operation, hold DONE for 'hold' cycles, then consume.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] tv,
                      input int hold, output logic [15:0] res, output int lat);
    if8.a = av; if8.b = bv; if8.trunc = tv; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
    check("w8_pre_in_ready", if8.in_ready, 1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    lat = 1;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = if8.o;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("w8_hold_valid", if8.out_valid, 1);
      check("w8_hold_o", if8.o, res);
      check("w8_hold_in_ready", if8.in_ready, 0);
    end
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    check("w8_back_idle", if8.in_ready, 1);
    check("w8_idle_out_valid", if8.out_valid, 0);
    check("w8_idle_o", if8.o, 0);
  endtask

  task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [4:0] tv,
                       output logic [31:0] res, output int lat);
    if16.a = av; if16.b = bv; if16.trunc = tv; if16.in_valid = 1'b1; if16.out_ready = 1'b0;
    @(posedge clk); #1;
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    res = if16.o;
    if16.out_ready = 1'b1;
    @(posedge clk); #1;
    if16.out_ready = 1'b0;
    check("w16_back_idle", if16.in_ready, 1);
  endtask

  initial begin
    logic [15:0] r8;
    logic [31:0] r16;
    logic [7:0]  ra, rb;
    logic [3:0]  rt;
    int          lat;
    int          accepts  = 0;
    int          products = 0;
    bit          got;

    if8.in_valid = 1'b1; if8.a = 8'hAA; if8.b = 8'h55; if8.trunc = '0; if8.out_ready = 1'b1;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.trunc = '0; if16.out_ready = 1'b0;

    // Reset overrides a pending handshake.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", if8.in_ready, 1);
    check("rst_out_valid", if8.out_valid, 0);
    check("rst_busy", if8.busy, 0);
    check("rst_o", if8.o, 0);
    rst = 1'b0;
    if8.in_valid = 1'b0; if8.out_ready = 1'b0;

    // Basic product and fixed latency; first accept right after reset release.
    run8(8'h12, 8'h34, 4'd0, 0, r8, lat);
    check("basic_o", r8, 16'h03A8);
    check("basic_lat", lat, 9);

    run8(8'hFF, 8'hFF, 4'd0, 0, r8, lat);
    check("ff_t0", r8, 16'hFE01);
    run8(8'hFF, 8'hFF, 4'd8, 0, r8, lat);
    check("ff_t8", r8, 16'hF700);
    // Columns 15 and above hold no partial products for 8x8.
    run8(8'hFF, 8'hFF, 4'd15, 0, r8, lat);
    check("ff_t15", r8, 16'h0000);
    run8(8'hFF, 8'hFF, 4'd14, 0, r8, lat);
    check("ff_t14", r8, 16'h4000);
    run8(8'h80, 8'h81, 4'd7, 0, r8, lat);
    check("t7_partial", r8, 16'h4080);

    // Backpressure in DONE.
    run8(8'hFF, 8'hFF, 4'd0, 5, r8, lat);
    check("bp_o", r8, 16'hFE01);
    check("bp_lat", lat, 9);

    // New operands offered mid-operation must be ignored until IDLE.
    if8.a = 8'h12; if8.b = 8'h34; if8.trunc = 4'd0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.a = 8'h01; if8.b = 8'h01;
    check("busy_calc", if8.busy, 1);
    lat = 1;
    while (!if8.out_valid && lat < 40) begin
      check("ign_in_ready", if8.in_ready, 0);
      @(posedge clk); #1; lat++;
    end
    check("ign_o", if8.o, 16'h03A8);
    check("ign_lat", lat, 9);
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
    check("ign_idle", if8.in_ready, 1);
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    check("second_accepted", if8.busy, 1);
    lat = 1;
    while (!if8.out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("second_o", if8.o, 16'h0001);
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;

    // Reset in the middle of CALC (j=4) discards the operation.
    if8.a = 8'h12; if8.b = 8'h34; if8.trunc = 4'd0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy", if8.busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_out_valid", if8.out_valid, 0);
    check("mid_rst_in_ready", if8.in_ready, 1);
    check("mid_rst_o", if8.o, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("mid_rst_no_stale", if8.out_valid, 0);
    end
    run8(8'h03, 8'h05, 4'd0, 0, r8, lat);
    check("after_rst_o", r8, 16'h000F);
    check("after_rst_lat", lat, 9);

    // W=16 directed.
    run16(16'hFFFF, 16'hFFFF, 5'd0, r16, lat);
    check("w16_ff", r16, 32'hFFFE0001);
    check("w16_lat", lat, 17);
    run16(16'h1234, 16'h5678, 5'd0, r16, lat);
    check("w16_1234", r16, 32'h06260060);

    // Randomised W=8 pass with random consumer backpressure.
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rt = 4'($urandom_range(0, 15));
      if8.a = ra; if8.b = rb; if8.trunc = rt; if8.in_valid = 1'b1;
      @(posedge clk); #1;
      if8.in_valid = 1'b0;
      accepts++;
      got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
        if8.out_ready = 1'($urandom_range(0, 1));
        if (if8.out_valid && if8.out_ready) begin
          check("rnd8_o", if8.o, model(8, 32'(ra), 32'(rb), int'(rt)));
          products++;
          got = 1'b1;
        end
        @(posedge clk); #1;
      end
      if8.out_ready = 1'b0;
    end
    check("rnd8_count", products, accepts);

    // Randomised W=16 operands and truncation against the model.
    for (int n = 0; n < 6; n++) begin
      logic [15:0] xa, xb;
      logic [4:0]  xt;
      xa = 16'($urandom); xb = 16'($urandom); xt = 5'($urandom_range(0, 31));
      run16(xa, xb, xt, r16, lat);
      check("rnd16_o", r16, model(16, 32'(xa), 32'(xb), int'(xt)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
